// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
// The optional write-through read path is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one reservation bit per register, set by the
// rsv handshake, cleared by an accepted write or by the clear sweep.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  state_e        state,
  input  logic [AW-1:0] sweep_idx,
  input  logic          wr_acc,
  input  logic [AW-1:0] waddr,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic          rsv_ready,
  output logic          busy_a,
  output logic          busy_b
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             rsv_fire;

  assign rsv_ready = !pend_q[rsv_addr] && (state == IDLE);
  assign rsv_fire  = rsv_valid && rsv_ready;
  assign busy_a    = pend_q[raddr_a];
  assign busy_b    = pend_q[raddr_b];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pend_d = pend_q;
    if (state == SWEEP) pend_d[sweep_idx] = 1'b0;
    if (wr_acc)         pend_d[waddr]     = 1'b0;
    // A reservation landing with a write to the same register wins.
    if (rsv_fire)       pend_d[rsv_addr]  = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_d;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, a reservation scoreboard
// and a one-register-per-cycle clear sweep. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [AW-1:0]          raddr_a,
  output logic [WIDTH-1:0]       rdata_a,
  input  logic [AW-1:0]          raddr_b,
  output logic [WIDTH-1:0]       rdata_b,
  output logic                   busy_a,
  output logic                   busy_b,
  input  logic                   rsv_valid,
  input  logic [AW-1:0]          rsv_addr,
  output logic                   rsv_ready,
  input  logic                   clr,
  output logic                   clr_busy,
  output logic [DEPTH*WIDTH-1:0] regs_flat
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wr_acc;

  assign wr_acc   = we && (state_q == IDLE);
  assign clr_busy = (state_q == SWEEP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (wr_acc) regs_d[waddr] = wdata;
        // A same-cycle clr lets the write land first; the sweep clears it later.
        if (clr) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        regs_d[idx_q] = '0;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the array is small flop storage that must read 0 after reset, so it is reset like any other state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // wr_acc is never set in SWEEP, so the bypass cannot apply mid-sweep.
  always_comb begin
    rdata_a = (wr_acc && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
    rdata_b = (wr_acc && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];
  end
`else
  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
  end
`endif

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .state     (state_q),
    .sweep_idx (idx_q),
    .wr_acc    (wr_acc),
    .waddr     (waddr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .rsv_ready (rsv_ready),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width of every register in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the register count, a power of two and at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH), SHALL set the address width; it is derived and not overridden.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 we  input  1, waddr  input  AW, wdata  input  WIDTH SHALL form the write port.
REQ-007 raddr_a  input  AW, rdata_a  output  WIDTH SHALL form read port A, which is combinational.
REQ-008 raddr_b  input  AW, rdata_b  output  WIDTH SHALL form read port B, which is combinational.
REQ-009 busy_a  output  1, busy_b  output  1 SHALL show the pending bit of raddr_a and raddr_b.
REQ-010 rsv_valid  input  1, rsv_addr  input  AW, rsv_ready  output  1 SHALL form the reservation handshake.
REQ-011 clr  input  1 SHALL request a clear sweep, and clr_busy  output  1 SHALL flag that a sweep is in progress.
REQ-012 regs_flat  output  DEPTH*WIDTH SHALL expose all registers for debug, with register i at bits [i*WIDTH +: WIDTH].

Function
REQ-013 Writes SHALL be synchronous: when we=1 and state is IDLE, register waddr takes wdata at the clock edge.
REQ-014 rdata_a and rdata_b SHALL reflect the register contents combinationally, and the two ports SHALL be independent; equal addresses are allowed.
REQ-015 The block SHALL hold one pending bit per register.
REQ-016 rsv_ready SHALL equal !pend[rsv_addr] && state==IDLE.
REQ-017 A reservation SHALL complete when rsv_valid && rsv_ready, setting pend[rsv_addr] at the edge.
REQ-018 An accepted write SHALL clear pend[waddr]; a write to a register that is not pending is legal and leaves its pending bit at 0.
REQ-019 If a write and a completed reservation target the same address in the same cycle, the data SHALL be written and pend SHALL end at 1.
REQ-020 The FSM SHALL have two states, IDLE and SWEEP.
REQ-021 clr=1 in IDLE SHALL move the FSM to SWEEP with idx=0; clr in SWEEP SHALL be ignored.
REQ-022 In each SWEEP cycle, reg[idx] and pend[idx] SHALL be set to 0 and idx SHALL increment; at idx==DEPTH-1 the FSM SHALL return to IDLE.
REQ-023 A sweep SHALL therefore last exactly DEPTH cycles, and clr_busy SHALL be 1 only in SWEEP.
REQ-024 During SWEEP, we SHALL be ignored and rsv_ready SHALL be 0; reads SHALL stay live and show partially cleared contents.
REQ-025 A clr and a we in the same IDLE cycle SHALL perform the write, then start the sweep on the next edge, so the written register is later cleared.
REQ-026 idx SHALL be AW bits wide and SHALL NOT wrap beyond DEPTH-1.

Reset
REQ-027 With reset_n=0 at a clock edge, all registers and all pending bits SHALL clear to 0, state SHALL be IDLE and idx SHALL be 0.
REQ-028 Reset SHALL take priority over write, reservation and clr, including when asserted mid-sweep, which aborts the sweep.
REQ-029 After reset: rdata_a=rdata_b=0, busy_a=busy_b=0, rsv_ready=1, clr_busy=0 and regs_flat=0.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined, a read port whose address equals waddr while a write is accepted SHALL return wdata in that cycle, i.e. write-through.
REQ-031 Without REGFILE_BYPASS_EN, reads SHALL return the stored, pre-write value until the edge.
REQ-032 Bypass SHALL never apply during SWEEP.

Structure
REQ-033 A shared package regfile_pkg SHALL hold the FSM state typedef (IDLE, SWEEP) and the default WIDTH and DEPTH constants.
REQ-034 The single sub-module regfile_scoreboard SHALL own the pending bits, rsv_ready, busy_a and busy_b.
REQ-035 The data array, the FSM and the bypass logic SHALL stay in regfile_sb.

Verification
REQ-036 Write/read: with WIDTH=4 and DEPTH=4, write 0xA to reg 2 and 0x5 to reg 3, then raddr_a=2 and raddr_b=3 -> rdata_a=0xA, rdata_b=0x5.
REQ-037 Bypass: we=1, waddr=1, wdata=0xC, raddr_a=1 with old value 0 -> rdata_a=0xC in the same cycle with REGFILE_BYPASS_EN, and 0x0 without it.
REQ-038 Scoreboard: reserve reg 1, then reserve reg 1 again -> rsv_ready=0 and busy_a=1 at raddr_a=1; write reg 1 -> the next cycle gives busy_a=0 and rsv_ready=1.
REQ-039 Collision: reserve and write reg 0 in the same cycle with wdata=0x7 -> reg0=0x7 and pend[0]=1.
REQ-040 Sweep: load 0xF into all regs, pulse clr -> clr_busy=1 for exactly 4 cycles, a we issued mid-sweep is dropped, and regs_flat=0 afterwards.
REQ-041 Reset mid-sweep: reset_n=0 during the second SWEEP cycle -> the next cycle gives state IDLE, clr_busy=0 and all registers 0.
